// File: rtl/seq_sub_64_bit.sv
// Multi-cycle 64-bit subtractor: d = a - b - b_in, SLICE_W bits per clock, LSB slice first.
// Define SEQ_SUB_OVF_EN to add the registered signed-overflow output ovf.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// BUSY  | computing one slice per clock, N_SLICES cycles
// DONE  | result held on d/b_out until out_ready
module seq_sub_64_bit #(
    parameter int SLICE_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        b_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] d,
    output logic        b_out
`ifdef SEQ_SUB_OVF_EN
    ,
    output logic        ovf
`endif
);

    localparam int N_SLICES = 64 / SLICE_W;
    localparam int CNT_W    = (N_SLICES > 1) ? $clog2(N_SLICES) : 1;
    localparam int SUM_W    = SLICE_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_SLICES - 1);

    generate
        if (SLICE_W != 1 && SLICE_W != 2 && SLICE_W != 4 && SLICE_W != 8 &&
            SLICE_W != 16 && SLICE_W != 32 && SLICE_W != 64) begin : g_bad_slice_w
            $error("seq_sub_64_bit: SLICE_W must be one of 1, 2, 4, 8, 16, 32, 64");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [63:0]        a_q, a_d;
    logic [63:0]        b_q, b_d;
    logic               c_q, c_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [63:0]        d_q, d_d;
    logic               b_out_q, b_out_d;
`ifdef SEQ_SUB_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    logic [6:0]         slice_base;
    logic [SLICE_W-1:0] a_sl;
    logic [SLICE_W-1:0] b_sl;
    logic [SLICE_W-1:0] sum_sl;
    logic               c_nx;

    // Subtraction as a + ~b + carry, where the initial carry is ~b_in.
    always_comb begin
        slice_base       = 7'(cnt_q) * 7'(SLICE_W);
        a_sl             = a_q[slice_base +: SLICE_W];
        b_sl             = b_q[slice_base +: SLICE_W];
        {c_nx, sum_sl}   = {1'b0, a_sl} + {1'b0, ~b_sl} + SUM_W'(c_q);
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        b_out_d = b_out_q;
`ifdef SEQ_SUB_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    c_d     = ~b_in;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                d_d[slice_base +: SLICE_W] = sum_sl;
                c_d = c_nx;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    b_out_d = ~c_nx;
`ifdef SEQ_SUB_OVF_EN
                    ovf_d   = (a_q[63] != b_q[63]) && (d_d[63] != a_q[63]);
`endif
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            d_q     <= '0;
            b_out_q <= 1'b0;
`ifdef SEQ_SUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            b_out_q <= b_out_d;
`ifdef SEQ_SUB_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign d         = d_q;
    assign b_out     = b_out_q;
`ifdef SEQ_SUB_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_seq_sub_64_bit.sv
// Scoreboard bench for seq_sub_64_bit, run on SLICE_W = 16, 1 and 64 instances side by side.
// Honours SEQ_SUB_OVF_EN when the design is built with it.
module tb_seq_sub_64_bit;

    localparam int N_DUT = 3;

    typedef struct packed {
        logic [63:0] d;
        logic        bo;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_v       [N_DUT];
    logic        in_valid_v  [N_DUT];
    logic        in_ready_v  [N_DUT];
    logic [63:0] a_v         [N_DUT];
    logic [63:0] b_v         [N_DUT];
    logic        b_in_v      [N_DUT];
    logic        out_valid_v [N_DUT];
    logic        out_ready_v [N_DUT];
    logic [63:0] d_v         [N_DUT];
    logic        b_out_v     [N_DUT];
    logic        ovf_v       [N_DUT];

    int          n_cmp = 0;
    int          n_err = 0;
    int          cur_dut = 0;
    exp_t        sb_q[$];

    seq_sub_64_bit #(.SLICE_W(16)) u_dut_w16 (
        .clk(clk), .rst(rst_v[0]), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .a(a_v[0]), .b(b_v[0]), .b_in(b_in_v[0]), .out_valid(out_valid_v[0]),
        .out_ready(out_ready_v[0]), .d(d_v[0]), .b_out(b_out_v[0])
`ifdef SEQ_SUB_OVF_EN
        , .ovf(ovf_v[0])
`endif
    );

    seq_sub_64_bit #(.SLICE_W(1)) u_dut_w1 (
        .clk(clk), .rst(rst_v[1]), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .a(a_v[1]), .b(b_v[1]), .b_in(b_in_v[1]), .out_valid(out_valid_v[1]),
        .out_ready(out_ready_v[1]), .d(d_v[1]), .b_out(b_out_v[1])
`ifdef SEQ_SUB_OVF_EN
        , .ovf(ovf_v[1])
`endif
    );

    seq_sub_64_bit #(.SLICE_W(64)) u_dut_w64 (
        .clk(clk), .rst(rst_v[2]), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .a(a_v[2]), .b(b_v[2]), .b_in(b_in_v[2]), .out_valid(out_valid_v[2]),
        .out_ready(out_ready_v[2]), .d(d_v[2]), .b_out(b_out_v[2])
`ifdef SEQ_SUB_OVF_EN
        , .ovf(ovf_v[2])
`endif
    );

`ifndef SEQ_SUB_OVF_EN
    initial for (int i = 0; i < N_DUT; i++) ovf_v[i] = 1'b0;
`endif

    function automatic int n_slices(input int i);
        return (i == 0) ? 4 : (i == 1) ? 64 : 1;
    endfunction

    function automatic exp_t model(input logic [63:0] av, input logic [63:0] bv, input logic bi);
        logic [64:0] r;
        exp_t        e;
        r     = {1'b0, av} - {1'b0, bv} - 65'(bi);
        e.d   = r[63:0];
        e.bo  = r[64];
        e.ovf = (av[63] != bv[63]) && (r[63] != av[63]);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL dut%0d %s: got %h expected %h", cur_dut, tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input int i, input logic [63:0] av, input logic [63:0] bv,
                          input logic bi, input int hold, input bit wiggle);
        int   lat;
        exp_t e;
        cur_dut = i;
        lat = 0;
        while (!in_ready_v[i] && lat < 300) begin
            step();
            lat++;
        end
        chk("in_ready_before_issue", 64'(in_ready_v[i]), 64'd1);
        in_valid_v[i]  = 1'b1;
        a_v[i]         = av;
        b_v[i]         = bv;
        b_in_v[i]      = bi;
        out_ready_v[i] = (hold == 0);
        step();
        sb_q.push_back(model(av, bv, bi));
        in_valid_v[i] = 1'b0;
        chk("in_ready_busy", 64'(in_ready_v[i]), 64'd0);
        lat = 0;
        while (!out_valid_v[i] && lat < 300) begin
            if (wiggle) begin
                a_v[i]        = {$urandom, $urandom};
                b_v[i]        = {$urandom, $urandom};
                b_in_v[i]     = 1'($urandom);
                in_valid_v[i] = 1'($urandom);
            end
            step();
            lat++;
        end
        in_valid_v[i] = 1'b0;
        chk("latency", 64'(lat), 64'(n_slices(i)));
        e = sb_q[0];
        for (int k = 0; k < hold; k++) begin
            chk("hold_out_valid", 64'(out_valid_v[i]), 64'd1);
            chk("hold_in_ready", 64'(in_ready_v[i]), 64'd0);
            chk("hold_d", d_v[i], e.d);
            chk("hold_b_out", 64'(b_out_v[i]), 64'(e.bo));
            step();
        end
        out_ready_v[i] = 1'b1;
        e = sb_q.pop_front();
        chk("out_valid_at_pop", 64'(out_valid_v[i]), 64'd1);
        chk("d", d_v[i], e.d);
        chk("b_out", 64'(b_out_v[i]), 64'(e.bo));
`ifdef SEQ_SUB_OVF_EN
        chk("ovf", 64'(ovf_v[i]), 64'(e.ovf));
`endif
        step();
        out_ready_v[i] = 1'b0;
        chk("out_valid_after_pop", 64'(out_valid_v[i]), 64'd0);
        chk("in_ready_after_pop", 64'(in_ready_v[i]), 64'd1);
    endtask

    task automatic run_abort(input int i);
        cur_dut = i;
        in_valid_v[i]  = 1'b1;
        a_v[i]         = 64'hDEAD_BEEF_0000_0001;
        b_v[i]         = 64'h0000_0000_1234_5678;
        b_in_v[i]      = 1'b1;
        out_ready_v[i] = 1'b0;
        step();
        in_valid_v[i] = 1'b0;
        step();
        rst_v[i] = 1'b1;
        step();
        rst_v[i] = 1'b0;
        chk("abort_in_ready", 64'(in_ready_v[i]), 64'd1);
        chk("abort_out_valid", 64'(out_valid_v[i]), 64'd0);
        chk("abort_d", d_v[i], 64'd0);
        chk("abort_b_out", 64'(b_out_v[i]), 64'd0);
        for (int k = 0; k < n_slices(i) + 3; k++) begin
            step();
            chk("abort_no_result", 64'(out_valid_v[i]), 64'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < N_DUT; i++) begin
            rst_v[i]       = 1'b1;
            in_valid_v[i]  = 1'b0;
            a_v[i]         = '0;
            b_v[i]         = '0;
            b_in_v[i]      = 1'b0;
            out_ready_v[i] = 1'b0;
        end
        repeat (3) step();
        for (int i = 0; i < N_DUT; i++) rst_v[i] = 1'b0;
        for (int i = 0; i < N_DUT; i++) begin
            cur_dut = i;
            chk("reset_in_ready", 64'(in_ready_v[i]), 64'd1);
            chk("reset_out_valid", 64'(out_valid_v[i]), 64'd0);
            chk("reset_d", d_v[i], 64'd0);
            chk("reset_b_out", 64'(b_out_v[i]), 64'd0);
`ifdef SEQ_SUB_OVF_EN
            chk("reset_ovf", 64'(ovf_v[i]), 64'd0);
`endif
        end

        for (int i = 0; i < N_DUT; i++) begin
            run_op(i, 64'd5, 64'd3, 1'b0, 0, 1'b0);
            run_op(i, 64'd0, 64'd1, 1'b0, 0, 1'b0);
            run_op(i, 64'd10, 64'd10, 1'b1, 0, 1'b0);
            run_op(i, 64'h0000_0000_0001_0000, 64'd1, 1'b0, 0, 1'b0);
            run_op(i, 64'h8000_0000_0000_0000, 64'd1, 1'b0, 0, 1'b0);
            run_op(i, 64'd3, 64'd5, 1'b0, 0, 1'b0);
            run_op(i, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0, 1'b0);
            run_op(i, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 0, 1'b0);
            run_op(i, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 10, 1'b0);
            run_op(i, 64'h1234_0000_0000_5678, 64'h0000_FFFF_FFFF_0001, 1'b1, 2, 1'b1);
            run_abort(i);
            run_op(i, 64'd5, 64'd3, 1'b0, 0, 1'b0);
            for (int r = 0; r < 4; r++) begin
                run_op(i, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom),
                       int'($urandom_range(0, 3)), 1'($urandom));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seq_sub_64_bit.md
Name: seq_sub_64_bit

Overview:
- Multi-cycle 64-bit subtractor: computes d = a - b - b_in one SLICE_W-bit slice per clock, least-significant slice first.
- It is the inverse-operation counterpart to the team's 64-bit ripple-carry adder.
- Serves datapath units that trade latency for a short critical path.
- Valid/ready handshake on both the operand side and the result side.

Parameters:
- SLICE_W, 16, slice width processed per cycle. Legal values are 1, 2, 4, 8, 16, 32 and 64. Any other value is a compile-time error.
- N_SLICES, 64/SLICE_W, derived and not overridable. It is the number of compute cycles.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands a, b, b_in are valid
- in_ready  output  1  block can accept operands
- a  input  64  minuend
- b  input  64  subtrahend
- b_in  input  1  borrow in
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- d  output  64  difference a - b - b_in, mod 2^64
- b_out  output  1  borrow out; 1 when the unsigned result a < b + b_in

Behaviour:
- Reset (rst=1 at clock edge):
  - state goes to IDLE.
  - in_ready=1, out_valid=0, d=0, b_out=0, slice counter=0.
  - Reset overrides every other input in that cycle.
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch a and b.
  - Set carry register c = ~b_in and cnt=0, then go to BUSY.
  - Operands are not sampled again until the block is back in IDLE.
- BUSY:
  - in_ready=0.
  - Each edge computes slice k=cnt: {c_next, d[k*SLICE_W +: SLICE_W]} = a_slice + ~b_slice + c.
  - Store c=c_next, then cnt=cnt+1.
  - After the edge that computes slice N_SLICES-1: b_out = ~c_next, go to DONE.
  - The BUSY state lasts exactly N_SLICES cycles.
- DONE:
  - out_valid=1, and d and b_out stay stable.
  - On an edge with out_ready=1: out_valid=0, in_ready=1, go to IDLE.
  - If out_ready=0, hold indefinitely. Nothing may change.
- Latency: out_valid rises N_SLICES edges after the accepting edge (4 with the default).
  - The accepting edge itself is the IDLE-to-BUSY edge.
  - Minimum issue interval is N_SLICES+2 cycles.
- No same-cycle pass-through: in_ready is 0 in DONE, so a new operand cannot be accepted on the same edge the result is popped.
- d bits of slices not yet computed in BUSY are don't-care. Only the value qualified by out_valid is checked.
- Inputs a, b and b_in may change freely after the accepting edge without affecting the result.
- Reset in BUSY or DONE aborts the operation, with no result or partial output delivered afterwards.
- out_ready asserted in IDLE or BUSY is ignored.
- Arithmetic wraps modulo 2^64.
  - Example: 0 - 1 gives d=FFFF_FFFF_FFFF_FFFF, b_out=1.
- SLICE_W=64 degenerates to one compute cycle; behaviour is otherwise identical.

Optional Feature:
- Macro: SEQ_SUB_OVF_EN.
- When defined:
  - Adds output port ovf (1 bit): the two's-complement signed overflow of a - b - b_in.
  - ovf = (a[63] != b[63]) && (d[63] != a[63]), using the latched a and b.
  - ovf is registered alongside b_out, is valid when out_valid=1, and resets to 0.
- When undefined: the port and its logic are absent, and all other behaviour is unchanged.

Test Plan:
- Basic subtraction: a=5, b=3, b_in=0, out_ready=1 → out_valid exactly 4 cycles after acceptance; d=2, b_out=0; in_ready returns to 1 the cycle after the pop.
- Underflow: a=0, b=1, b_in=0 → d=FFFF_FFFF_FFFF_FFFF, b_out=1. Also a=10, b=10, b_in=1 → d=FFFF_FFFF_FFFF_FFFF, b_out=1.
- Cross-slice borrow: a=0x0000_0000_0001_0000, b=1 → d=0x0000_0000_0000_FFFF, b_out=0. Proves the carry chains between slices.
- Backpressure:
  - Hold out_ready=0 for 10 cycles in DONE → d, b_out and out_valid are stable and in_ready=0.
  - Toggle a, b and in_valid during BUSY → result unaffected.
- Reset mid-operation: assert rst for one cycle at the second BUSY cycle → next cycle state is IDLE, in_ready=1, out_valid=0, d=0. A new operation afterwards completes correctly.
- With SEQ_SUB_OVF_EN: a=0x8000_0000_0000_0000, b=1 → d=0x7FFF_FFFF_FFFF_FFFF, ovf=1, b_out=0. Also a=3, b=5 → ovf=0, b_out=1.
- Repeat all of the above with SLICE_W=1 and SLICE_W=64.
